// File: rtl/pipe_stage_elastic_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic_pkg
//
// Shared definitions for the elastic pipeline register chain.
//   - stage_state_e : per-stage occupancy state. The encoding is chosen so
//                     that the state value equals the number of words held
//                     (EMPTY=0, ONE=1, TWO=2), which lets the state register
//                     double as the stage's word count.
//   - occ_width()   : width of the chain-level occupancy counter, sized to
//                     hold 0..2*depth.
// ---------------------------------------------------------------------------
package pipe_stage_elastic_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Each stage holds at most two words, so the chain holds at most 2*depth.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//
// One elastic pipeline stage built as a two-entry skid buffer. The upstream
// ready is a flop, so there is no combinational path from out_ready back to
// in_ready and no path from in_valid forward to out_valid. With out_ready
// held high the stage passes one word per cycle and never uses its skid
// register.
//
// Handshake: a word moves across a port on a rising edge where valid and
// ready are both high. valid never waits on ready; once valid is high the
// word and valid stay put until the transfer happens (or flush/clr).
//
// Ports
//   clk        rising-edge clock
//   clr        synchronous active-high reset: EMPTY, data regs <= RESET_VAL
//   flush      synchronous discard of held words (data regs keep values)
//   in_valid   upstream word present
//   in_ready   stage can accept a word (registered)
//   in_data    upstream payload
//   out_valid  stage holds a word (registered)
//   out_ready  downstream accepts
//   out_data   payload of the main register
//   count      words held (0..2); equal to the state encoding, and so also
//              serves as the FSM state view for debug
// ---------------------------------------------------------------------------
module pipe_skid_stage
  import pipe_stage_elastic_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  stage_state_e     state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             valid_q;
  logic             ready_q;

  logic in_fire;
  logic out_fire;

  // Both fire terms use only the local flops plus the partner's handshake
  // input, so each transfer is decided by this stage alone.
  assign in_fire  = in_valid & ready_q;
  assign out_fire = valid_q & out_ready;

  // valid_q tracks (state != EMPTY) and ready_q tracks (state != TWO); they
  // are kept as their own flops so the handshake outputs come straight from
  // registers rather than from a decode of the state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (flush) begin
      // Drop everything held, including a word arriving this cycle. The
      // data registers are left alone; only the state forgets them.
      state   <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q  <= in_data;
            state   <= ST_ONE;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end

        ST_ONE: begin
          if (in_fire && out_fire) begin
            // Pass-through: new word replaces the departing one.
            main_q <= in_data;
          end else if (in_fire) begin
            // Downstream stalled; park the new word behind the main word.
            skid_q  <= in_data;
            state   <= ST_TWO;
            ready_q <= 1'b0;
          end else if (out_fire) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
          end
        end

        ST_TWO: begin
          // ready_q is low here, so in_fire cannot occur.
          if (out_fire) begin
            main_q  <= skid_q;
            state   <= ST_ONE;
            ready_q <= 1'b1;
          end
        end

        default: begin
          state   <= ST_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;
  assign count     = state;

endmodule

// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
//
// Elastic pipeline register chain: DEPTH cascaded skid-buffer stages carrying
// a WIDTH-bit payload under valid/ready flow control. Nominal latency is
// DEPTH cycles; throughput is one word per cycle; while stalled the chain
// absorbs up to 2*DEPTH words before in_ready falls.
//
// Handshake: a word moves across a port on a rising edge where valid and
// ready are both high. valid never waits on ready; once valid is high the
// word and valid stay put until the transfer happens (or flush/clr).
//
// Ports
//   clk        rising-edge clock
//   clr        synchronous active-high reset (priority over flush/transfers)
//   flush      synchronous discard of all held words; a word delivered on
//              the flush cycle counts as delivered, an arriving one is lost
//   in_valid   upstream word present
//   in_ready   stage 0 can accept a word (registered)
//   in_data    upstream payload
//   out_valid  last stage holds a word
//   out_ready  downstream accepts
//   out_data   payload of the last stage's main register
//   occupancy  registered total of words held across all stages
// ---------------------------------------------------------------------------
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               OCC_W     = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  // Link k joins the output port of stage k-1 to the input port of stage k;
  // link 0 is the chain input and link DEPTH is the chain output.
  logic             ch_valid [DEPTH+1];
  logic             ch_ready [DEPTH+1];
  logic [WIDTH-1:0] ch_data  [DEPTH+1];

  // Per-stage word count, equal to each stage's FSM state encoding.
  logic [1:0]       stage_count [DEPTH];

  logic [OCC_W-1:0] count_sum;
  logic [OCC_W-1:0] occ_q;
  logic             chain_in_fire;
  logic             chain_out_fire;

  assign ch_valid[0]     = in_valid;
  assign ch_data[0]      = in_data;
  assign in_ready        = ch_ready[0];

  assign out_valid       = ch_valid[DEPTH];
  assign out_data        = ch_data[DEPTH];
  assign ch_ready[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_skid_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .clr       (clr),
      .flush     (flush),
      .in_valid  (ch_valid[k]),
      .in_ready  (ch_ready[k]),
      .in_data   (ch_data[k]),
      .out_valid (ch_valid[k+1]),
      .out_ready (ch_ready[k+1]),
      .out_data  (ch_data[k+1]),
      .count     (stage_count[k])
    );
  end

  // Words currently held, summed from the stage counts.
  always_comb begin
    count_sum = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_sum = count_sum + OCC_W'(stage_count[k]);
    end
  end

  assign chain_in_fire  = in_valid & ch_ready[0];
  assign chain_out_fire = ch_valid[DEPTH] & out_ready;

  // Internal stage-to-stage transfers conserve words, so the total after the
  // edge is the current sum plus the chain-boundary transfers. Registering
  // that keeps occupancy aligned with the stage counts on every cycle. The
  // sum cannot exceed 2*DEPTH: in_fire is impossible when stage 0 is full.
  always_ff @(posedge clk) begin
    if (clr || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= count_sum + OCC_W'(chain_in_fire) - OCC_W'(chain_out_fire);
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Three chains (DEPTH 2, 3, 4; WIDTH 8) share one set of driven inputs; the
// one selected by 'sel' sees in_valid/out_ready, the others idle. A negedge
// monitor keeps the scoreboard: accepted words are pushed to exp_q, delivered
// words are popped and compared, and occupancy is compared to the queue size.
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;
  int         sel;

  localparam logic [7:0] RV2 = 8'h5A;
  localparam logic [7:0] RV3 = 8'hC3;
  localparam logic [7:0] RV4 = 8'h00;

  // ---------------- DUTs ----------------
  logic       iv2, iv3, iv4, or2, or3, or4;
  logic       ir2, ir3, ir4, ov2, ov3, ov4;
  logic [7:0] od2, od3, od4;
  logic [2:0] occ2, occ3;
  logic [3:0] occ4;

  assign iv2 = in_valid && (sel == 2);
  assign iv3 = in_valid && (sel == 3);
  assign iv4 = in_valid && (sel == 4);
  assign or2 = out_ready && (sel == 2);
  assign or3 = out_ready && (sel == 3);
  assign or4 = out_ready && (sel == 4);

  pipe_stage_elastic #(.WIDTH(8), .DEPTH(2), .RESET_VAL(RV2)) u_d2 (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(iv2), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(occ2));

  pipe_stage_elastic #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV3)) u_d3 (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(iv3), .in_ready(ir3), .in_data(in_data),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .occupancy(occ3));

  pipe_stage_elastic #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV4)) u_d4 (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(iv4), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .occupancy(occ4));

  // Observed signals of the selected chain.
  logic       iv_m, or_m, ir_m, ov_m;
  logic [7:0] od_m;
  int         occ_m;

  always_comb begin
    iv_m = iv3; or_m = or3; ir_m = ir3; ov_m = ov3; od_m = od3; occ_m = int'(occ3);
    case (sel)
      2: begin iv_m = iv2; or_m = or2; ir_m = ir2; ov_m = ov2; od_m = od2; occ_m = int'(occ2); end
      4: begin iv_m = iv4; or_m = or4; ir_m = ir4; ov_m = ov4; od_m = od4; occ_m = int'(occ4); end
      default: ;
    endcase
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  int cyc = 0;
  int first_in, first_out, last_out, delivered, accepted, peak_occ;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [7:0] e;
    if (clr) begin
      exp_q.delete();
    end else begin
      check("occupancy", 32'(occ_m), 32'(exp_q.size()));
      if (occ_m > peak_occ) peak_occ = occ_m;
      if (ov_m && or_m) begin
        check("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(od_m), 32'(e));
        end
        delivered++;
        if (first_out < 0) first_out = cyc + 1;
        last_out = cyc + 1;
      end
      if (iv_m && ir_m) begin
        if (!flush) begin
          exp_q.push_back(in_data);
          accepted++;
        end
        if (first_in < 0) first_in = cyc + 1;
      end
      if (flush) exp_q.delete();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input int s);
    sel = s;
    #1;
  endtask

  task automatic clear_trackers();
    first_in  = -1;
    first_out = -1;
    last_out  = -1;
    delivered = 0;
    accepted  = 0;
    peak_occ  = 0;
  endtask

  task automatic check_reset_vals(input string tag, input logic [7:0] rv);
    check({tag, "_occ"},       32'(occ_m), 32'd0);
    check({tag, "_out_valid"}, 32'(ov_m),  32'd0);
    check({tag, "_in_ready"},  32'(ir_m),  32'd1);
    check({tag, "_out_data"},  32'(od_m),  32'(rv));
  endtask

  task automatic drain(input string tag, input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    sel = 3;
    clear_trackers();
    repeat (2) tick();
    clr = 1'b0;

    // Reset values of every chain.
    select(2); check_reset_vals("init_d2", RV2);
    select(4); check_reset_vals("init_d4", RV4);
    select(3); check_reset_vals("init_d3", RV3);

    // Streaming, DEPTH=3, out_ready held high.
    clear_trackers();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("stream_count",    32'(delivered), 32'd3);
    check("stream_latency",  32'(first_out - first_in), 32'd3);
    check("stream_b2b",      32'(last_out - first_out), 32'd2);
    check("stream_peak_occ", 32'(peak_occ), 32'd3);

    // Fill DEPTH=3 to 6 words, then clr.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = 8'($urandom_range(0, 255));
      tick();
    end
    in_valid = 1'b0;
    check("full_occ",      32'(occ_m), 32'd6);
    check("full_in_ready", 32'(ir_m),  32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_reset_vals("clr_full", RV3);

    // Fill/stall, DEPTH=2.
    select(2);
    clear_trackers();
    begin
      logic f;
      int   n_acc;
      n_acc     = 0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        f = ir_m;
        tick();
        if (f) begin
          n_acc++;
          in_data = in_data + 8'd1;
        end
      end
      in_valid = 1'b0;
      check("stall_accepted", 32'(n_acc), 32'd4);
    end
    check("stall_in_ready", 32'(ir_m),  32'd0);
    check("stall_occ",      32'(occ_m), 32'd4);
    check("stall_out_data", 32'(od_m),  32'hA0);
    drain("stall", 20);
    check("stall_delivered", 32'(delivered), 32'd4);

    // Flush collision, DEPTH=3: 0x44 delivered on the flush cycle, 0x55 lost.
    out_ready = 1'b0;
    select(3);
    clear_trackers();
    in_valid = 1'b1; in_data = 8'h44;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("flush_setup_valid", 32'(ov_m), 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_delivered", 32'(delivered), 32'd1);
    check("flush_occ",       32'(occ_m), 32'd0);
    check("flush_out_valid", 32'(ov_m),  32'd0);
    check("flush_in_ready",  32'(ir_m),  32'd1);
    repeat (6) tick();
    check("flush_no_ghost",  32'(delivered), 32'd1);

    // clr together with flush, mid-stream.
    clear_trackers();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'($urandom_range(0, 255));
      tick();
    end
    clr = 1'b1; flush = 1'b1;
    tick();
    clr = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_reset_vals("clr_flush", RV3);
    delivered = 0;
    repeat (8) tick();
    check("clr_flush_no_output", 32'(delivered), 32'd0);

    // Random backpressure, DEPTH=4.
    out_ready = 1'b0;
    select(4);
    clear_trackers();
    for (int i = 0; i < 2000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      // Alternate between light and heavy backpressure phases.
      if ((i / 200) % 2 == 0) out_ready = ($urandom_range(0, 3) != 0);
      else                    out_ready = ($urandom_range(0, 3) == 0);
      tick();
    end
    drain("random", 60);
    check("random_conservation", 32'(delivered), 32'(accepted));
    check("random_activity",     32'(accepted > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
